// File: rtl/bus_ram_pkg.sv
// Shared bus-slave definitions: FSM state encoding, byte-lane masks, latched request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_ram_pkg;

  // Bus slave handshake phases, 2-bit encoding shared with the CPU side.
  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_ACCESS = 2'd1,
    BUS_HOLD   = 2'd2
  } bus_state_e;

  // Byte-lane enable masks; bit k enables data bits [8k+7:8k].
  localparam logic [3:0] SEL_BYTE0   = 4'b0001;
  localparam logic [3:0] SEL_BYTE1   = 4'b0010;
  localparam logic [3:0] SEL_BYTE2   = 4'b0100;
  localparam logic [3:0] SEL_BYTE3   = 4'b1000;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_WORD    = 4'b1111;

  // Request captured on strobe. Only the word address is kept; adr[1:0]
  // carries no information for a 32-bit word slave.
  typedef struct packed {
    logic        we;
    logic [29:0] wadr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } bus_req_t;

endpackage

// File: rtl/bus_ram_ram_be32.sv
// Storage array: 2^ADDR_WIDTH x 32 synchronous RAM with per-byte write enables.
// Latency: write and read both take effect at the clock edge; read data is registered.
// Backpressure: none; every enabled cycle is serviced.
//
// Ports:
//   clk     rising-edge clock
//   re_i    read enable; rdat_o loads mem[addr_i] on the edge, otherwise holds
//   we_i    byte write enables, bit k writes wdat_i[8k+7:8k]
//   addr_i  word index
//   wdat_i  write data (lane aligned)
//   rdat_o  registered read data
module ram_be32 #(
  parameter int ADDR_WIDTH = 12,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  re_i,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdat_i,
  output logic [31:0]           rdat_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdat_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we_i[k]) begin
        mem_q[addr_i][8*k +: 8] <= wdat_i[8*k +: 8];
      end
    end
    if (re_i) begin
      rdat_q <= mem_q[addr_i];
    end
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/bus_ram.sv
// On-chip memory slave for the CPU bus: latches a strobed request, performs a byte-masked word access.
// Latency: ack_o rises after edge t0+1+WAIT_STATES (t0 = edge that samples stb_i high).
// Backpressure: four-phase; ack_o and dat_o are held until the master drops stb_i, then ack_o falls.
//
// Ports:
//   clk     system clock, rising edge
//   rst_i   synchronous active-high reset
//   stb_i   request strobe from master
//   we_i    1 = write, 0 = read
//   adr_i   byte address (bits [1:0] ignored)
//   dat_i   write data, lane aligned
//   sel_i   byte-lane enables
//   ack_o   access complete, level held while stb_i stays high
//   dat_o   registered read data
//   err_o   sticky out-of-range flag, cleared only by reset
module bus_ram
  import bus_ram_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        err_o
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  bus_state_e  state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  bus_req_t    req_q, req_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  // When set, dat_o reads as zero: after reset and after an out-of-range read.
  // The RAM's own read register then only has to be loaded on in-range reads.
  logic        zero_q, zero_d;

  logic        in_range;
  logic        ram_re;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdat;

  logic        unused_adr_lsb;
  assign unused_adr_lsb = ^adr_i[1:0];

  // Upper address bits must match the aligned base; the rest index the array.
  assign in_range = (req_q.wadr[29:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH+2]);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    req_d   = req_q;
    ack_d   = ack_q;
    err_d   = err_q;
    zero_d  = zero_q;
    ram_re  = 1'b0;
    ram_we  = 4'b0000;

    unique case (state_q)
      BUS_IDLE: begin
        ack_d = 1'b0;
        if (stb_i) begin
          req_d.we   = we_i;
          req_d.wadr = adr_i[31:2];
          req_d.dat  = dat_i;
          req_d.sel  = sel_i;
          wcnt_d     = WAIT_CNT;
          state_d    = BUS_ACCESS;
        end
      end

      // The latched request completes even if stb_i is withdrawn here.
      BUS_ACCESS: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          ack_d   = 1'b1;
          state_d = BUS_HOLD;
          if (!in_range) begin
            // Still acknowledged so the master never hangs; writes dropped.
            err_d = 1'b1;
            if (!req_q.we) begin
              zero_d = 1'b1;
            end
          end else if (req_q.we) begin
            ram_we = req_q.sel;
          end else begin
            ram_re = 1'b1;
            zero_d = 1'b0;
          end
        end
      end

      // A high strobe here only extends the hold; never a new request.
      BUS_HOLD: begin
        if (!stb_i) begin
          ack_d   = 1'b0;
          state_d = BUS_IDLE;
        end
      end

      default: begin
        ack_d   = 1'b0;
        state_d = BUS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= BUS_IDLE;
      wcnt_q  <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  // Request latch carries no control meaning, so it is not reset.
  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

  ram_be32 #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .re_i   (ram_re),
    .we_i   (ram_we),
    .addr_i (req_q.wadr[ADDR_WIDTH-1:0]),
    .wdat_i (req_q.dat),
    .rdat_o (ram_rdat)
  );

  assign ack_o = ack_q;
  assign dat_o = zero_q ? 32'h0000_0000 : ram_rdat;
  assign err_o = err_q;

endmodule
